// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one external 32-bit adder.
// One operation at a time: grant in IDLE, wait ADD_LAT cycles in EXEC, hold result in RESP.
module adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADD_LAT = 1,
  localparam int unsigned ID_W   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  output logic [31:0]             add_a,
  output logic [31:0]             add_b,
  input  logic [32:0]             add_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [32:0]             rsp_sum,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     add_a_q, add_a_d;
  logic [31:0]     add_b_q, add_b_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [32:0]     rsp_sum_q, rsp_sum_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [31:0]     op_a [NUM_REQ];
  logic [31:0]     op_b [NUM_REQ];
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_found;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_a[i] = req_a[i*32 +: 32];
      op_b[i] = req_b[i*32 +: 32];
    end
  end

  // First valid requester at or after ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = ID_W'((32'(ptr_q) + off) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Gated by rst_n so the grant drops immediately when reset asserts.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          add_a_d  = op_a[gnt_idx];
          add_b_d  = op_b[gnt_idx];
          rsp_id_d = gnt_idx;
          ptr_d    = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
          cnt_d    = 4'(ADD_LAT);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rsp_sum_d   = add_result;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != IDLE);

endmodule
